// File: rtl/spi_data_shifter.sv
// spi_data_shifter: serial data path of the SPI master.
// Takes one parallel TX word over valid/ready, asks the SCLK/slave-select
// generator for a transaction, shifts the word out on MOSI and collects MISO
// into an RX word that is presented when slave select rises again.
module spi_data_shifter #(
    parameter int DATA_SIZE = 16
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst,
    input  logic [DATA_SIZE-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    input  logic                 i_cpol,
    input  logic                 i_cpha,
    input  logic                 i_lsb_first,
    output logic                 o_spi_start,
    input  logic                 i_ss_start,
    input  logic                 i_sclk,
    input  logic                 i_miso,
    output logic                 o_mosi,
    output logic [DATA_SIZE-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_abort,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(DATA_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_SIZE);

    // One-hot state encoding
    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_START = 4'b0010;
    localparam logic [3:0] S_XFER  = 4'b0100;
    localparam logic [3:0] S_DONE  = 4'b1000;

    logic [3:0]           state;
    logic [3:0]           state_next;
    logic [DATA_SIZE-1:0] tx_sr;
    logic [DATA_SIZE-1:0] rx_sr;
    logic [DATA_SIZE-1:0] rx_sr_shifted;
    logic [DATA_SIZE-1:0] rx_sr_final;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic                 sclk_d;
    logic                 cpol_q;
    logic                 cpha_q;
    logic                 lsb_q;
    logic                 accept;
    logic                 in_xfer;
    logic                 lead_edge;
    logic                 trail_edge;
    logic                 sample_en;
    logic                 shift_en;
    logic                 cnt_full_next;
    logic                 finish_ev;
    logic                 abort_ev;

    assign o_tx_ready  = (state == S_IDLE);
    assign o_busy      = (state != S_IDLE);
    assign o_spi_start = (state == S_START);
    assign o_mosi      = lsb_q ? tx_sr[0] : tx_sr[DATA_SIZE-1];
    assign accept      = i_tx_valid && o_tx_ready;
    assign in_xfer     = (state == S_XFER);

    // SCLK edge classification relative to the latched idle polarity, plus
    // the sample/shift strobes and the look-ahead sample count
    always_comb begin
        lead_edge  = (sclk_d == cpol_q) && (i_sclk != cpol_q);
        trail_edge = (sclk_d != cpol_q) && (i_sclk == cpol_q);
        sample_en  = in_xfer && (bit_cnt != CNT_FULL) &&
                     (cpha_q ? trail_edge : lead_edge);
        // With cpha=1 the first bit is already on MOSI, so the first leading
        // edge (no sample taken yet) must not shift.
        shift_en   = in_xfer && (bit_cnt != CNT_FULL) &&
                     (cpha_q ? (lead_edge && (bit_cnt != '0)) : trail_edge);
        rx_sr_shifted = lsb_q ? {i_miso, rx_sr[DATA_SIZE-1:1]}
                              : {rx_sr[DATA_SIZE-2:0], i_miso};
        rx_sr_final   = sample_en ? rx_sr_shifted : rx_sr;
        bit_cnt_next  = bit_cnt + CNT_W'(sample_en);
        cnt_full_next = (bit_cnt_next == CNT_FULL);
        // A final sample landing in the same cycle as select rising still
        // completes the word.
        finish_ev  = i_ss_start && ((in_xfer && cnt_full_next) || (state == S_DONE));
        abort_ev   = i_ss_start && in_xfer && !cnt_full_next;
    end

    // Next-state decode of the transaction sequencer
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = S_START;
            end
            S_START: begin
                // Request is held until select actually falls, since the
                // generator may still be in its inter-transaction wait.
                if (!i_ss_start) state_next = S_XFER;
            end
            S_XFER: begin
                if (i_ss_start)         state_next = S_IDLE;
                else if (cnt_full_next) state_next = S_DONE;
            end
            S_DONE: begin
                if (i_ss_start) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) state <= S_IDLE;
        else           state <= state_next;
    end

    // SCLK history for edge detection, updated every cycle
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) sclk_d <= 1'b0;
        else           sclk_d <= i_sclk;
    end

    // Per-transaction mode bits, frozen at accept
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            lsb_q  <= 1'b0;
        end else if (accept) begin
            cpol_q <= i_cpol;
            cpha_q <= i_cpha;
            lsb_q  <= i_lsb_first;
        end
    end

    // TX shift register: load on accept, move one bit toward MOSI per shift
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            tx_sr <= '0;
        end else if (accept) begin
            tx_sr <= i_tx_data;
        end else if (shift_en) begin
            if (lsb_q) tx_sr <= {1'b0, tx_sr[DATA_SIZE-1:1]};
            else       tx_sr <= {tx_sr[DATA_SIZE-2:0], 1'b0};
        end
    end

    // RX shift register and sample counter
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else if (sample_en) begin
            rx_sr   <= rx_sr_shifted;
            bit_cnt <= bit_cnt_next;
        end
    end

    // Completion / abort reporting towards the host
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
            o_abort    <= 1'b0;
        end else begin
            o_rx_valid <= finish_ev;
            o_abort    <= abort_ev;
            if (finish_ev) o_rx_data <= rx_sr_final;
        end
    end

endmodule

// File: tb/tb_spi_data_shifter.sv
// Bench for spi_data_shifter: a behavioural SCLK/select generator and slave
// drive the DUT; received words are checked through an expected-value queue.
module tb_spi_data_shifter;

    logic        clk;
    logic        rst;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cpol;
    logic        cpha;
    logic        lsb_first;
    logic        spi_start;
    logic        ss;
    logic        sclk;
    logic        miso;
    logic        mosi;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        abort_p;
    logic        busy;

    spi_data_shifter #(.DATA_SIZE(16)) dut (
        .i_sys_clk   (clk),
        .i_sys_rst   (rst),
        .i_tx_data   (tx_data),
        .i_tx_valid  (tx_valid),
        .o_tx_ready  (tx_ready),
        .i_cpol      (cpol),
        .i_cpha      (cpha),
        .i_lsb_first (lsb_first),
        .o_spi_start (spi_start),
        .i_ss_start  (ss),
        .i_sclk      (sclk),
        .i_miso      (miso),
        .o_mosi      (mosi),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .o_abort     (abort_p),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] tx;
        logic        cpol;
        logic        cpha;
        logic        lsb;
        logic        loop;
        logic [15:0] slave_word;
        logic [15:0] exp_rx;
    } vec_t;

    vec_t        vecs [5];
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    int          checks;
    int          errors;
    int          rx_pulses;
    int          abort_pulses;

    // Output monitor: records every completed word and abort pulse
    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
            rx_pulses++;
        end
        if (abort_p) abort_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic sb_check(input string name);
        logic [15:0] e;
        logic [15:0] g;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        checks++;
        if (got_q.size() == 0) begin
            errors++;
            $display("FAIL %s actual=none required=%0h", name, e);
        end else begin
            g = got_q.pop_front();
            if (g !== e) begin
                errors++;
                $display("FAIL %s actual=%0h required=%0h", name, g, e);
            end
        end
    endtask

    // Present a word for one accept edge, then drop valid
    task automatic start_word(input logic [15:0] w, input logic p, input logic h, input logic l);
        @(negedge clk);
        tx_data = w; cpol = p; cpha = h; lsb_first = l; sclk = p; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Generator + slave: waits for the request, drops select, runs nbits SCLK
    // periods (4 system cycles each) and optionally raises select.
    task automatic gen_xfer(input logic p, input logic h, input logic l, input logic loop,
                            input logic [15:0] sword, input int nbits,
                            input bit release_ss, input bit merge_last,
                            output logic [15:0] captured);
        int          t;
        logic        b;
        logic [15:0] cap;
        cap = '0;
        t = 0;
        while (spi_start !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL spi_start_wait actual=timeout required=request");
            captured = cap;
            return;
        end
        @(negedge clk);
        ss = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < nbits; k++) begin
            b = l ? sword[k] : sword[15-k];
            sclk = ~p;
            if (!h) begin
                miso = loop ? mosi : b;
                if (l) cap[k] = mosi; else cap[15-k] = mosi;
            end else if (!loop) begin
                miso = b;
            end
            repeat (2) @(negedge clk);
            sclk = p;
            if (h) begin
                miso = loop ? mosi : b;
                if (l) cap[k] = mosi; else cap[15-k] = mosi;
            end
            if (merge_last && k == nbits - 1) ss = 1'b1;
            else repeat (2) @(negedge clk);
        end
        if (release_ss && !merge_last) ss = 1'b1;
        captured = cap;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [15:0] cap;
        start_word(v.tx, v.cpol, v.cpha, v.lsb);
        exp_q.push_back(v.exp_rx);
        chk({tag, "_ready_low"}, tx_ready, 1'b0);
        chk({tag, "_start_req"}, spi_start, 1'b1);
        chk({tag, "_first_bit"}, mosi, v.lsb ? v.tx[0] : v.tx[15]);
        gen_xfer(v.cpol, v.cpha, v.lsb, v.loop, v.slave_word, 16, 1'b1, 1'b0, cap);
        chk({tag, "_slave_rx"}, cap, v.tx);
        @(negedge clk);
        chk({tag, "_rx_valid"}, rx_valid, 1'b1);
        chk({tag, "_ready_back"}, tx_ready, 1'b1);
        @(negedge clk);
        chk({tag, "_rx_valid_once"}, rx_valid, 1'b0);
        sb_check({tag, "_rx_data"});
    endtask

    initial begin
        logic [15:0] cap1;
        logic [15:0] cap2;
        int          pulses_before;
        int          held;

        checks = 0; errors = 0; rx_pulses = 0; abort_pulses = 0;
        rst = 1'b1; tx_data = '0; tx_valid = 1'b0; cpol = 1'b0; cpha = 1'b0;
        lsb_first = 1'b0; ss = 1'b1; sclk = 1'b0; miso = 1'b0;

        //          tx       cpol  cpha  lsb   loop  slave    exp_rx
        vecs[0] = '{16'hA55A, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hA55A};
        vecs[1] = '{16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1234};
        vecs[2] = '{16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0001};
        vecs[3] = '{16'h3C96, 1'b1, 1'b0, 1'b0, 1'b0, 16'hC3A5, 16'hC3A5};
        vecs[4] = '{16'h8001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h7FFE, 16'h7FFE};

        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", spi_start, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_abort", abort_p, 1'b0);
        chk("rst_rx_data", rx_data, 16'h0000);
        chk("rst_mosi", mosi, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back words with valid held and the generator in its wait
        @(negedge clk);
        tx_data = 16'h1111; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; sclk = 1'b0;
        tx_valid = 1'b1;
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        @(negedge clk);
        chk("b2b_ready_low", tx_ready, 1'b0);
        tx_data = 16'h2222;
        gen_xfer(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16, 1'b1, 1'b0, cap1);
        chk("b2b_slave_rx1", cap1, 16'h1111);
        @(negedge clk);
        chk("b2b_rx_valid1", rx_valid, 1'b1);
        @(negedge clk);
        chk("b2b_second_accept", tx_ready, 1'b0);
        tx_valid = 1'b0;
        held = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (spi_start === 1'b1) held++;
        end
        chk("b2b_start_held", held, 6);
        gen_xfer(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16, 1'b1, 1'b0, cap2);
        chk("b2b_slave_rx2", cap2, 16'h2222);
        @(negedge clk);
        chk("b2b_rx_valid2", rx_valid, 1'b1);
        @(negedge clk);
        sb_check("b2b_word1");
        sb_check("b2b_word2");

        // Abort after 5 samples; previous word must stay visible
        run_vec(vecs[0], "pre_abort");
        pulses_before = rx_pulses;
        start_word(16'h5555, 1'b0, 1'b0, 1'b0);
        gen_xfer(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 5, 1'b1, 1'b0, cap1);
        @(negedge clk);
        chk("abort_pulse", abort_p, 1'b1);
        chk("abort_no_valid", rx_valid, 1'b0);
        chk("abort_rx_kept", rx_data, 16'hA55A);
        chk("abort_idle", tx_ready, 1'b1);
        @(negedge clk);
        chk("abort_once", abort_p, 1'b0);
        chk("abort_no_rx_pulse", rx_pulses, pulses_before);
        chk("abort_count", abort_pulses, 1);

        // Final sample and select rise in the same cycle: completes
        start_word(16'hC0DE, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(16'hC0DE);
        gen_xfer(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16, 1'b1, 1'b1, cap1);
        @(negedge clk);
        chk("merge_rx_valid", rx_valid, 1'b1);
        chk("merge_no_abort", abort_p, 1'b0);
        @(negedge clk);
        sb_check("merge_rx_data");

        // Reset in the middle of a transfer, then a clean transaction
        start_word(16'hF00F, 1'b0, 1'b0, 1'b0);
        gen_xfer(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8, 1'b0, 1'b0, cap1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", tx_ready, 1'b1);
        chk("midrst_rx_data", rx_data, 16'h0000);
        chk("midrst_start", spi_start, 1'b0);
        chk("midrst_mosi", mosi, 1'b0);
        ss = 1'b1;
        @(negedge clk);
        run_vec('{16'h6A6A, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h6A6A}, "post_rst");
        chk("abort_total", abort_pulses, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_data_shifter.md
# spi_data_shifter

Serial data path of the SPI master, directly downstream of the SCLK/slave-select generator. Accepts parallel TX words over a valid/ready handshake and requests a transaction from the generator. Drives MOSI from a shift register in step with the generator's SCLK and samples MISO into an RX shift register. Returns each received word with a one-cycle valid strobe once slave select deasserts.

## Interface
- DATA_SIZE, 16, bits per transaction; must equal the generator's DATA_SIZE; ≥2.
- i_sys_clk  in  1  system clock; all logic on rising edge.
- i_sys_rst  in  1  synchronous reset, active high.
- i_tx_data  in  DATA_SIZE  word to transmit; captured on accept.
- i_tx_valid  in  1  TX word available.
- o_tx_ready  out  1  high only in IDLE; accept = i_tx_valid & o_tx_ready at a clock edge.
- i_cpol  in  1  clock polarity; captured on accept; must match the generator's CPOL.
- i_cpha  in  1  clock phase; captured on accept.
- i_lsb_first  in  1  1 = LSB shifted first; captured on accept.
- o_spi_start  out  1  transaction request to the generator.
- i_ss_start  in  1  generator's slave select, active low (1 = deselected).
- i_sclk  in  1  generator's SCLK, already synchronous to i_sys_clk.
- i_miso  in  1  serial data from slave.
- o_mosi  out  1  serial data to slave.
- o_rx_data  out  DATA_SIZE  last complete received word; holds until next completion.
- o_rx_valid  out  1  one-cycle pulse when o_rx_data updates.
- o_abort  out  1  one-cycle pulse when select deasserts before DATA_SIZE samples.
- o_busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, START, XFER, DONE. One-hot encoding.
- IDLE: o_tx_ready=1.
  - On accept: load tx_sr=i_tx_data, latch cpol/cpha/lsb_first, clear rx_sr and bit_cnt, go START.
- START: o_spi_start=1.
  - On i_ss_start==0: go XFER with o_spi_start=0 from that edge.
  - Holding the request is mandatory: the generator may be in its inter-transaction wait and would miss a single-cycle pulse.
- Edge detect:
  - sclk_d <= i_sclk every cycle.
  - Leading edge: sclk_d==cpol and i_sclk!=cpol.
  - Trailing edge: sclk_d!=cpol and i_sclk==cpol.
- XFER sample/shift edges:
  - cpha=0: sample on leading edge, shift on trailing edge.
  - cpha=1: shift on leading edge, sample on trailing edge.
- XFER shift register behaviour:
  - o_mosi = tx_sr[DATA_SIZE-1] if !lsb_first, else tx_sr[0].
  - Shift moves tx_sr one position toward the output end.
  - The first bit is valid on o_mosi from the cycle after accept, i.e. before select falls.
  - cpha=1: the first leading edge performs no shift; the first bit is presented from accept.
- XFER sample behaviour:
  - Sample pushes i_miso into rx_sr: into the LSB end with shift left if !lsb_first, into the MSB end with shift right if lsb_first.
  - Sample increments bit_cnt, width $clog2(DATA_SIZE+1), saturating at DATA_SIZE.
  - Samples and shifts after bit_cnt==DATA_SIZE are ignored.
- XFER exit:
  - i_ss_start==1 with bit_cnt==DATA_SIZE: o_rx_data<=rx_sr, o_rx_valid pulse, go IDLE.
  - i_ss_start==1 with bit_cnt<DATA_SIZE: o_abort pulse, o_rx_data unchanged, go IDLE.
- DONE: entered from XFER when bit_cnt reaches DATA_SIZE while select is still low; waits for i_ss_start==1, then behaves as the completion exit above.
- Simultaneous final sample and select rise in the same cycle: the sample counts, and the transaction completes, not aborts.
- Reset (any state, including mid-transfer):
  - State IDLE; o_spi_start=0, o_rx_valid=0, o_abort=0.
  - o_rx_data=0, tx_sr=0, rx_sr=0, bit_cnt=0, sclk_d=0.
  - o_mosi=0, o_tx_ready=1 (IDLE), o_busy=0.

## Timing
- Accept at edge T: o_tx_ready=0 and o_spi_start=1 from T+1.
- i_ss_start seen low at edge S: o_spi_start=0 from S+1.
- Edge detected at edge E: the shift/sample takes effect at E, so o_mosi changes from E+1.
- MISO is sampled on the system clock cycle the SCLK edge is detected.
- The generator's clock period must be ≥4 system cycles.
- i_ss_start seen high at edge D: o_rx_valid or o_abort is high during cycle D+1 only. o_tx_ready=1 from D+1.
- Accept is possible at D+1, giving back-to-back words. Spacing between transactions is set by the generator's inter-transaction wait.
- Only one word is in flight; no buffering. i_tx_valid may stay high; the next accept occurs at the next IDLE.

## Test plan
- Mode 0, MSB first, tx 0xA55A, MISO looped to MOSI → o_rx_data=0xA55A, one o_rx_valid pulse, exactly 16 samples.
- Mode 3 (cpol=1, cpha=1), slave model returns 0x1234, tx 0xBEEF → slave receives 0xBEEF; o_rx_data=0x1234.
- LSB first, mode 1, tx 0x0001 → o_mosi high for the first bit only; loopback o_rx_data=0x0001.
- i_tx_valid held high with words 0x1111 then 0x2222, generator busy in its inter-transaction wait at the second request → o_spi_start held until select falls; both words transmitted in order; two o_rx_valid pulses.
- Select forced high after 5 samples → o_abort pulse, no o_rx_valid, o_rx_data keeps its previous value 0xA55A, returns to IDLE.
- i_sys_rst asserted for 1 cycle mid-XFER → next cycle o_busy=0, o_tx_ready=1, o_rx_data=0; a new accept then completes normally.
